// File: rtl/pipe_perf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_perf_pkg
// Description : Shared FSM state encoding and default stop instruction.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [31:0] C_STOP_INST_DEFAULT = 32'h0000_00EF;

endpackage : pipe_perf_pkg
`default_nettype wire

// File: rtl/pipe_perf_counters_ch.sv
`default_nettype none
// ============================================================================
// Module      : perf_ch_counter
// Description : One channel's high/low event counters with sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_ch_counter #(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_count,
  input  logic             i_event,
  output logic [CNT_W-1:0] o_hi,
  output logic [CNT_W-1:0] o_lo,
  output logic             o_ovf
);

  logic [CNT_W-1:0] r_hi;
  logic [CNT_W-1:0] r_lo;
  logic             r_ovf;
  logic             w_hi_full;
  logic             w_lo_full;

  assign w_hi_full = &r_hi;
  assign w_lo_full = &r_lo;

  // An increment at all-ones either holds or wraps; both flag the overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_ovf <= 1'b0;
    end else if (i_count) begin
      if (i_event) begin
        if (w_hi_full) begin
          r_ovf <= 1'b1;
          if (SATURATE == 0) r_hi <= '0;
        end else begin
          r_hi <= r_hi + CNT_W'(1);
        end
      end else begin
        if (w_lo_full) begin
          r_ovf <= 1'b1;
          if (SATURATE == 0) r_lo <= '0;
        end else begin
          r_lo <= r_lo + CNT_W'(1);
        end
      end
    end
  end

  assign o_hi  = r_hi;
  assign o_lo  = r_lo;
  assign o_ovf = r_ovf;

endmodule : perf_ch_counter
`default_nettype wire

// File: rtl/pipe_perf_counters.sv
`default_nettype none
// ============================================================================
// Module      : pipe_perf_counters
// Description : Per-channel pipeline event counters gated by a start/stop FSM,
//               with snapshot shadow registers and a channel readout mux.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_perf_counters
  import pipe_perf_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 32,
  parameter int          SATURATE  = 1,
  parameter logic [31:0] STOP_INST = C_STOP_INST_DEFAULT
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [31:0]                                inst,
  input  logic                                       inst_vld,
  input  logic [NUM_CH-1:0]                          event_i,
  input  logic                                       clr_i,
  input  logic                                       snap_i,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sel_i,
  output logic [CNT_W-1:0]                           hi_cnt_o,
  output logic [CNT_W-1:0]                           lo_cnt_o,
  output logic [NUM_CH-1:0]                          ovf_o,
  output logic [1:0]                                 state_o
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e                         r_state;
  state_e                         w_next;
  logic                           w_count;
  logic                           w_stop;
  logic                           w_any;
  logic [NUM_CH-1:0][CNT_W-1:0]   w_hi;
  logic [NUM_CH-1:0][CNT_W-1:0]   w_lo;
  logic [NUM_CH-1:0][CNT_W-1:0]   r_sh_hi;
  logic [NUM_CH-1:0][CNT_W-1:0]   r_sh_lo;

  assign w_stop = inst_vld && (inst == STOP_INST);
  assign w_any  = |event_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // The stop match outranks the start trigger; the unused code behaves as IDLE.
  always_comb begin
    w_next  = r_state;
    w_count = 1'b0;
    if (clr_i) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_stop) w_next = ST_HALT;
          else        w_count = 1'b1;
        end
        ST_HALT: w_next = ST_HALT;
        default: begin
          if (w_stop) begin
            w_next = ST_HALT;
          end else if (w_any) begin
            w_next  = ST_RUN;
            w_count = 1'b1;
          end else begin
            w_next = ST_IDLE;
          end
        end
      endcase
    end
  end

  assign state_o = r_state;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      perf_ch_counter #(
        .CNT_W    (CNT_W),
        .SATURATE (SATURATE)
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (clr_i),
        .i_count (w_count),
        .i_event (event_i[g]),
        .o_hi    (w_hi[g]),
        .o_lo    (w_lo[g]),
        .o_ovf   (ovf_o[g])
      );
    end
  endgenerate

  // Shadows capture pre-update values, so a coincident clear still snapshots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_hi <= '0;
      r_sh_lo <= '0;
    end else if (snap_i) begin
      r_sh_hi <= w_hi;
      r_sh_lo <= w_lo;
    end
  end

  always_comb begin
    hi_cnt_o = '0;
    lo_cnt_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_i == SEL_W'(c)) begin
        hi_cnt_o = r_sh_hi[c];
        lo_cnt_o = r_sh_lo[c];
      end
    end
  end

endmodule : pipe_perf_counters
`default_nettype wire

// File: tb/tb_pipe_perf_counters.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_perf_counters
// Description : Directed self-checking bench for pipe_perf_counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_perf_counters;

  localparam logic [31:0] STOP = 32'h0000_00EF;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic        inst_vld;
  logic [3:0]  ev;
  logic        clr;
  logic        snap;
  logic [1:0]  sel;
  logic [2:0]  sel6;

  logic [31:0] d_hi, d_lo, x_hi, x_lo;
  logic [7:0]  s_hi, s_lo, w_hi, w_lo;
  logic [3:0]  d_ovf, s_ovf, w_ovf;
  logic [5:0]  x_ovf;
  logic [1:0]  d_st, s_st, w_st, x_st;

  int n_chk;
  int n_pass;

  pipe_perf_counters u_dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_vld(inst_vld), .event_i(ev),
    .clr_i(clr), .snap_i(snap), .sel_i(sel), .hi_cnt_o(d_hi), .lo_cnt_o(d_lo),
    .ovf_o(d_ovf), .state_o(d_st));

  pipe_perf_counters #(.CNT_W(8), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .inst(inst), .inst_vld(inst_vld), .event_i(ev),
    .clr_i(clr), .snap_i(snap), .sel_i(sel), .hi_cnt_o(s_hi), .lo_cnt_o(s_lo),
    .ovf_o(s_ovf), .state_o(s_st));

  pipe_perf_counters #(.CNT_W(8), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .inst(inst), .inst_vld(inst_vld), .event_i(ev),
    .clr_i(clr), .snap_i(snap), .sel_i(sel), .hi_cnt_o(w_hi), .lo_cnt_o(w_lo),
    .ovf_o(w_ovf), .state_o(w_st));

  pipe_perf_counters #(.NUM_CH(6)) u_six (
    .clk(clk), .rst(rst), .inst(inst), .inst_vld(inst_vld), .event_i({2'b00, ev}),
    .clr_i(clr), .snap_i(snap), .sel_i(sel6), .hi_cnt_o(x_hi), .lo_cnt_o(x_lo),
    .ovf_o(x_ovf), .state_o(x_st));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; inst = '0; inst_vld = 1'b0; ev = '0; clr = 1'b0; snap = 1'b0;
    sel = '0; sel6 = '0;
    #12;
    chk("reset_hi", d_hi, 0);
    chk("reset_lo", d_lo, 0);
    chk("reset_state", d_st, 0);
    chk("reset_ovf", d_ovf, 0);
    rst = 1'b0;

    // Basic run: 3 idle, 5 high on ch0, 2 low, stop, snapshot
    ev = 4'b0000; repeat (3) cyc();
    chk("idle_hold", d_st, 0);
    ev = 4'b0001; repeat (5) cyc();
    chk("run_state", d_st, 1);
    ev = 4'b0000; repeat (2) cyc();
    inst = STOP; inst_vld = 1'b1; cyc(); inst_vld = 1'b0; inst = '0;
    chk("halt_state", d_st, 2);
    snap = 1'b1; cyc(); snap = 1'b0;
    sel = 2'd0; #1;
    chk("ch0_hi", d_hi, 5);
    chk("ch0_lo", d_lo, 2);
    sel = 2'd1; #1;
    chk("ch1_hi", d_hi, 0);
    chk("ch1_lo", d_lo, 7);
    ev = 4'hF; repeat (3) cyc();
    snap = 1'b1; cyc(); snap = 1'b0; ev = 4'h0;
    sel = 2'd0; #1;
    chk("halt_frozen_hi", d_hi, 5);
    chk("halt_frozen_lo", d_lo, 2);

    // Clear leaves shadows; then clear+snap together
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("clr_state", d_st, 0);
    chk("clr_shadow_kept", d_hi, 5);
    ev = 4'b0011; repeat (10) cyc();
    chk("run2_state", d_st, 1);
    clr = 1'b1; snap = 1'b1; ev = 4'b0000; cyc(); clr = 1'b0; snap = 1'b0;
    chk("clrsnap_hi", d_hi, 10);
    chk("clrsnap_state", d_st, 0);
    chk("clrsnap_ovf", d_ovf, 0);
    sel = 2'd2; #1;
    chk("clrsnap_ch2_lo", d_lo, 10);
    snap = 1'b1; cyc(); snap = 1'b0;
    chk("live_zero_lo", d_lo, 0);

    // Event and stop in the same idle cycle
    ev = 4'hF; inst = STOP; inst_vld = 1'b1; cyc(); inst_vld = 1'b0; inst = '0;
    chk("evstop_state", d_st, 2);
    repeat (4) cyc();
    snap = 1'b1; cyc(); snap = 1'b0; ev = 4'h0;
    sel = 2'd0; #1;
    chk("evstop_hi", d_hi, 0);
    chk("evstop_lo", d_lo, 0);

    // 300 high cycles on ch0: saturate vs wrap at 8 bits
    clr = 1'b1; cyc(); clr = 1'b0;
    ev = 4'b0001; repeat (300) cyc();
    ev = 4'b0000; snap = 1'b1; cyc(); snap = 1'b0;
    sel = 2'd0; sel6 = 3'd5; #1;
    chk("sat_hi", s_hi, 255);
    chk("wrap_hi", w_hi, 44);
    chk("wide_hi", d_hi, 300);
    chk("sat_ovf", s_ovf, 4'hF);
    chk("wrap_ovf", w_ovf, 4'hF);
    chk("wide_ovf", d_ovf, 0);
    chk("six_ch5_lo", x_lo, 300);
    sel = 2'd1; sel6 = 3'd6; #1;
    chk("sat_lo", s_lo, 255);
    chk("wrap_lo", w_lo, 44);
    chk("six_sel6_lo", x_lo, 0);
    chk("six_sel6_hi", x_hi, 0);
    sel6 = 3'd7; #1;
    chk("six_sel7_lo", x_lo, 0);
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("ovf_cleared", s_ovf, 0);

    // Asynchronous reset mid-run
    ev = 4'b0001; repeat (3) cyc();
    snap = 1'b1; cyc(); snap = 1'b0;
    sel = 2'd0; #1;
    chk("pre_rst_hi", d_hi, 3);
    chk("pre_rst_state", d_st, 1);
    rst = 1'b1; #1;
    chk("async_rst_hi", d_hi, 0);
    chk("async_rst_state", d_st, 0);
    rst = 1'b0; ev = 4'b0000; #1;
    repeat (2) cyc();
    chk("post_rst_idle", d_st, 0);
    ev = 4'b0001; cyc(); ev = 4'b0000;
    chk("retrigger_state", d_st, 1);
    snap = 1'b1; cyc(); snap = 1'b0;
    chk("retrigger_hi", d_hi, 1);
    chk("retrigger_lo", d_lo, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_pipe_perf_counters
`default_nettype wire
